gf_syndrome_seq: RTL and testbench



---
 rtl/gf_syndrome_seq.sv | 130 +++++++++++++
 tb/tb_gf_syndrome_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_syndrome_seq.sv
// ---------------------------------------------------------------------------
// gf_syndrome_seq
//
// Reed-Solomon syndrome sequencer over GF(2^SIZE). It computes
// S_k = r(alpha^(k0+k)) for k = 0..NSYN-1. One shared, purely combinational
// polynomial evaluator sits outside this block. That evaluator is driven
// through eval_p/eval_x and read back through eval_y. One evaluation point
// is captured per clock.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   request; only looked at while idle
//   flat_r    in   received polynomial, coefficient i at [i*SIZE +: SIZE]
//   eval_p    out  latched copy of flat_r, to the evaluator polynomial input
//   eval_x    out  current evaluation point, to the evaluator x input
//   eval_y    in   evaluator result for eval_p at eval_x
//   busy      out  high while evaluating and during the done cycle
//   done      out  one-cycle pulse; syn_flat/syn_zero are valid
//   syn_flat  out  syndromes, S_k at [k*SIZE +: SIZE]
//   syn_zero  out  all syndromes zero (no detected error)
// ---------------------------------------------------------------------------
module gf_syndrome_seq #(
  parameter int              m         = 255,
  parameter int              SIZE      = $clog2(m),
  parameter int              n         = 2,
  parameter int              flat_size = (n + 1) * SIZE,
  parameter int              NSYN      = 2,
  parameter logic [SIZE-1:0] PRIM      = 8'h1D,
  parameter logic [SIZE-1:0] ALPHA0    = 8'h02
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [flat_size-1:0]   flat_r,
  output logic [flat_size-1:0]   eval_p,
  output logic [SIZE-1:0]        eval_x,
  input  logic [SIZE-1:0]        eval_y,
  output logic                   busy,
  output logic                   done,
  output logic [NSYN*SIZE-1:0]   syn_flat,
  output logic                   syn_zero
);

  // The counter must be able to hold NSYN itself. This keeps NSYN=1 legal,
  // because that case needs a counter with a nonzero width.
  localparam int            CW     = $clog2(NSYN + 1);
  localparam logic [CW-1:0] K_LAST = CW'(NSYN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       k;
  logic [NSYN*SIZE-1:0] syn_next;

  // Multiply by alpha: shift left and reduce by the primitive polynomial.
  // Repeated application walks alpha^k0, alpha^(k0+1), ... through the field.
  function automatic logic [SIZE-1:0] xtime(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] sh;
    sh = {v[SIZE-2:0], 1'b0};
    if (v[SIZE-1]) begin
      return sh ^ PRIM;
    end
    return sh;
  endfunction

  // Syndrome vector as it will look after this cycle's capture. The final
  // capture derives syn_zero from this vector, so the newest syndrome is
  // included in the check.
  always_comb begin
    syn_next = syn_flat;
    for (int i = 0; i < NSYN; i++) begin
      if (k == CW'(i)) begin
        syn_next[i*SIZE +: SIZE] = eval_y;
      end
    end
  end

  // done and busy are pure decodes of the state register. This leaves no
  // combinational path from any input to either output.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      eval_p   <= '0;
      eval_x   <= '0;
      syn_flat <= '0;
      syn_zero <= 1'b0;
    end else begin
      case (state)
        // Idle: previous results stay visible until a new start arrives.
        IDLE: begin
          if (start) begin
            eval_p   <= flat_r;
            eval_x   <= ALPHA0;
            k        <= '0;
            syn_flat <= '0;
            syn_zero <= 1'b0;
            state    <= EVAL;
          end
        end
        // Eval: eval_p/eval_x have been stable all cycle, so eval_y has settled.
        EVAL: begin
          syn_flat <= syn_next;
          eval_x   <= xtime(eval_x);
          k        <= k + CW'(1);
          if (k == K_LAST) begin
            syn_zero <= (syn_next == '0);
            state    <= DONE;
          end
        end
        // Done: exactly one cycle of done/busy; start is ignored here.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_syndrome_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_syndrome_seq
//
// Directed bench for gf_syndrome_seq. A behavioural GF(2^8) polynomial
// evaluator stands in for gf_poly_eval on each instance. There are three
// instances: the default (NSYN=2), a wrap instance (NSYN=8, ALPHA0=80) and
// a minimal instance (NSYN=1). Expected syndromes are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_gf_syndrome_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] flat_r;
  logic        start_a, start_w, start_1;

  // default instance
  logic [23:0] p_a;
  logic [7:0]  x_a, y_a;
  logic        busy_a, done_a, zero_a;
  logic [15:0] syn_a;

  // wrap instance
  logic [23:0] p_w;
  logic [7:0]  x_w, y_w;
  logic        busy_w, done_w, zero_w;
  logic [63:0] syn_w;

  // single-syndrome instance
  logic [23:0] p_1;
  logic [7:0]  x_1, y_1;
  logic        busy_1, done_1, zero_1;
  logic [7:0]  syn_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] poly_eval(input logic [23:0] p, input logic [7:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 2; i >= 0; i--) begin
      acc = gf_mul(acc, x) ^ p[i*8 +: 8];
    end
    return acc;
  endfunction

  assign y_a = poly_eval(p_a, x_a);
  assign y_w = poly_eval(p_w, x_w);
  assign y_1 = poly_eval(p_1, x_1);

  gf_syndrome_seq u_dut (
    .clk(clk), .rst(rst), .start(start_a), .flat_r(flat_r),
    .eval_p(p_a), .eval_x(x_a), .eval_y(y_a),
    .busy(busy_a), .done(done_a), .syn_flat(syn_a), .syn_zero(zero_a)
  );

  gf_syndrome_seq #(.NSYN(8), .ALPHA0(8'h80)) u_wrap (
    .clk(clk), .rst(rst), .start(start_w), .flat_r(flat_r),
    .eval_p(p_w), .eval_x(x_w), .eval_y(y_w),
    .busy(busy_w), .done(done_w), .syn_flat(syn_w), .syn_zero(zero_w)
  );

  gf_syndrome_seq #(.NSYN(1)) u_one (
    .clk(clk), .rst(rst), .start(start_1), .flat_r(flat_r),
    .eval_p(p_1), .eval_x(x_1), .eval_y(y_1),
    .busy(busy_1), .done(done_1), .syn_flat(syn_1), .syn_zero(zero_1)
  );

  // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_w = 1'b1; start_1 = 1'b1;
    flat_r = 24'h020701;
    tick();
    tick();
    checks++;
    if ({busy_a, done_a, zero_a, syn_a, x_a, p_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b zero=%b syn=%h x=%h p=%h required all 0",
               busy_a, done_a, zero_a, syn_a, x_a, p_a);
    end
    checks++;
    if ({busy_w, done_w, syn_w, busy_1, done_1, syn_1} !== '0) begin
      errors++;
      $display("FAIL reset_other_inst: busy_w=%b syn_w=%h busy_1=%b syn_1=%h required 0",
               busy_w, syn_w, busy_1, syn_1);
    end
    rst = 1'b0; start_a = 1'b0; start_w = 1'b0; start_1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: busy=%b done=%b required 0 0", i, busy_a, done_a);
      end
    end
  endtask

  task automatic test_basic();
    flat_r = 24'h020701; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (x_a !== 8'h02 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_e0: x=%h busy=%b done=%b required 02 1 0", x_a, busy_a, done_a);
    end
    tick();
    checks++;
    if (x_a !== 8'h04 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_e1: x=%h done=%b required 04 0", x_a, done_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || syn_a !== 16'h3D07 || zero_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b syn=%h zero=%b required 1 1 3d07 0",
               done_a, busy_a, syn_a, zero_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || syn_a !== 16'h3D07) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b syn=%h required 0 0 3d07", done_a, busy_a, syn_a);
    end
  endtask

  task automatic test_codeword();
    flat_r = 24'h010608; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL cw_early_done: done=%b required 0", done_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || syn_a !== 16'h0000 || zero_a !== 1'b1) begin
      errors++;
      $display("FAIL cw_done: done=%b syn=%h zero=%b required 1 0000 1", done_a, syn_a, zero_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || zero_a !== 1'b1) begin
      errors++;
      $display("FAIL cw_pulse_width: done=%b zero=%b required 0 1", done_a, zero_a);
    end
  endtask

  task automatic test_back_to_back();
    flat_r = 24'h020701; start_a = 1'b1;
    tick();                       // accepted
    flat_r = 24'h000000;          // start stays high through EVAL and DONE
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || syn_a !== 16'h3D07) begin
      errors++;
      $display("FAIL busy_start_eval: done=%b syn=%h required 1 3d07", done_a, syn_a);
    end
    tick();                       // edge ending DONE with start=1 is ignored
    checks++;
    if (busy_a !== 1'b0 || syn_a !== 16'h3D07) begin
      errors++;
      $display("FAIL busy_start_done: busy=%b syn=%h required 0 3d07", busy_a, syn_a);
    end
    flat_r = 24'h010608;          // first IDLE cycle: accepted
    tick();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || x_a !== 8'h02 || syn_a !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b x=%h syn=%h required 1 02 0000", busy_a, x_a, syn_a);
    end
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || syn_a !== 16'h0000 || zero_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: done=%b syn=%h zero=%b required 1 0000 1", done_a, syn_a, zero_a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    flat_r = 24'h020701; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();                       // first capture done, now mid-EVAL
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || syn_a !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b syn=%h required 0 0 0000", busy_a, done_a, syn_a);
    end
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_a === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: done pulses=%0d required 0", seen_done);
    end
    flat_r = 24'h020701; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    checks++;
    if (done_a !== 1'b1 || syn_a !== 16'h3D07 || zero_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rerun: done=%b syn=%h zero=%b required 1 3d07 0", done_a, syn_a, zero_a);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_x [8];
    exp_x = '{8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13};
    flat_r = 24'h000001; start_w = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start_w = 1'b0;
      checks++;
      if (x_w !== exp_x[i] || done_w !== 1'b0) begin
        errors++;
        $display("FAIL wrap_x[%0d]: x=%h done=%b required %h 0", i, x_w, done_w, exp_x[i]);
      end
    end
    tick();
    checks++;
    if (done_w !== 1'b1 || syn_w !== 64'h0101010101010101 || zero_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_result: done=%b syn=%h zero=%b required 1 0101010101010101 0",
               done_w, syn_w, zero_w);
    end
    tick();
  endtask

  task automatic test_single();
    flat_r = 24'h020701; start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    checks++;
    if (x_1 !== 8'h02 || busy_1 !== 1'b1 || done_1 !== 1'b0) begin
      errors++;
      $display("FAIL one_e0: x=%h busy=%b done=%b required 02 1 0", x_1, busy_1, done_1);
    end
    tick();
    checks++;
    if (done_1 !== 1'b1 || syn_1 !== 8'h07 || zero_1 !== 1'b0) begin
      errors++;
      $display("FAIL one_done: done=%b syn=%h zero=%b required 1 07 0", done_1, syn_1, zero_1);
    end
    tick();
    checks++;
    if (done_1 !== 1'b0 || busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL one_after: done=%b busy=%b required 0 0", done_1, busy_1);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_w = 1'b0; start_1 = 1'b0; flat_r = '0;
    #1;
    test_reset();
    test_basic();
    test_codeword();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
